grid_mover: RTL

GRID_MOVER -- requirements
Module: grid_mover

---
 rtl/game_pkg.sv | 29 ++
 rtl/grid_mover_line_merge.sv | 61 ++++++
 rtl/grid_mover.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Types and constants shared by the move engine, tile generator and display logic.
// A board is grid[row][col], and each cell holds a tile exponent (0 means empty).
package game_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef logic [3:0] cell_t;
    typedef cell_t [3:0] line_t;
    typedef line_t [3:0] grid_t;

    localparam cell_t WIN_EXP = 4'd11;
    localparam cell_t MAX_EXP = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [19:0] expValue(input cell_t e);
        return 20'd1 << e;
    endfunction

endpackage

// File: rtl/grid_mover_line_merge.sv
// Combinational compact-and-merge of one line.
// Cell 0 of the line is the front, which is the side tiles slide toward.
module line_merge
    import game_pkg::*;
(
    input  line_t       line_i,
    output line_t       line_o,
    output logic [19:0] score_o,
    output logic        win_o
);

    line_t       packedLine;
    logic [3:0]  pairEq;
    logic [1:0]  wrCompact;
    logic [1:0]  wrMerge;
    logic        skip;
    cell_t       merged;

    // First squeeze out the empty cells, then merge left to right.
    // Skipping the partner cell makes each tile merge at most once.
    always_comb begin
        packedLine = '0;
        wrCompact  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (line_i[i] != 4'd0) begin
                packedLine[wrCompact] = line_i[i];
                wrCompact             = wrCompact + 2'd1;
            end
        end

        pairEq[3] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pairEq[i] = (packedLine[i] != 4'd0) && (packedLine[i] == packedLine[i+1]);
        end

        line_o  = '0;
        score_o = 20'd0;
        win_o   = 1'b0;
        skip    = 1'b0;
        wrMerge = 2'd0;
        merged  = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (pairEq[i]) begin
                merged          = (packedLine[i] == MAX_EXP) ? MAX_EXP : packedLine[i] + 4'd1;
                line_o[wrMerge] = merged;
                score_o         = score_o + expValue(merged);
                if (merged >= WIN_EXP) begin
                    win_o = 1'b1;
                end
                wrMerge = wrMerge + 2'd1;
                skip    = 1'b1;
            end else if (packedLine[i] != 4'd0) begin
                line_o[wrMerge] = packedLine[i];
                wrMerge         = wrMerge + 2'd1;
            end
        end
    end

endmodule

// File: rtl/grid_mover.sv
// 2048 move engine: it latches a board, merges one line per cycle in the chosen direction,
// and then presents the new board together with the score and the win and moved flags.
module grid_mover
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  dir_t        dir,
    input  grid_t       grid_in,
    output grid_t       grid_out,
    output logic        busy,
    output logic        done,
    output logic        moved,
    output logic [19:0] score_add,
    output logic        win
);

    state_t      state_q;
    dir_t        dir_q;
    grid_t       board_q;
    grid_t       board_d;
    logic [2:0]  lineIdx_q;
    logic [19:0] scoreAcc_q;
    logic        winAcc_q;
    logic        movedAcc_q;
    grid_t       gridOut_q;
    logic        busy_q;
    logic        done_q;
    logic        moved_q;
    logic [19:0] score_q;
    logic        win_q;

    line_t       lineIn;
    line_t       lineOut;
    logic [19:0] lineScore;
    logic        lineWin;
    logic [1:0]  idx;
    logic [1:0]  cellIdx;

    assign idx = lineIdx_q[1:0];

    // Read the current row or column front-first, then write the merged result back into the same cells.
    always_comb begin
        lineIn  = '0;
        board_d = board_q;
        cellIdx = 2'd0;
        for (int j = 0; j < 4; j++) begin
            cellIdx = 2'(j);
            unique case (dir_q)
                UP:    lineIn[j] = board_q[cellIdx][idx];
                DOWN:  lineIn[j] = board_q[~cellIdx][idx];
                LEFT:  lineIn[j] = board_q[idx][cellIdx];
                RIGHT: lineIn[j] = board_q[idx][~cellIdx];
                default: lineIn[j] = 4'd0;
            endcase
            unique case (dir_q)
                UP:    board_d[cellIdx][idx]  = lineOut[j];
                DOWN:  board_d[~cellIdx][idx] = lineOut[j];
                LEFT:  board_d[idx][cellIdx]  = lineOut[j];
                RIGHT: board_d[idx][~cellIdx] = lineOut[j];
                default: ;
            endcase
        end
    end

    line_merge u_line_merge (
        .line_i  (lineIn),
        .line_o  (lineOut),
        .score_o (lineScore),
        .win_o   (lineWin)
    );

    // Line indices 0 to 3 each process one line, and index 4 commits the results into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dir_q      <= UP;
            board_q    <= '0;
            lineIdx_q  <= 3'd0;
            scoreAcc_q <= 20'd0;
            winAcc_q   <= 1'b0;
            movedAcc_q <= 1'b0;
            gridOut_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            moved_q    <= 1'b0;
            score_q    <= 20'd0;
            win_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        board_q    <= grid_in;
                        dir_q      <= dir;
                        lineIdx_q  <= 3'd0;
                        scoreAcc_q <= 20'd0;
                        winAcc_q   <= 1'b0;
                        movedAcc_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (lineIdx_q[2]) begin
                        gridOut_q <= board_q;
                        moved_q   <= movedAcc_q;
                        score_q   <= scoreAcc_q;
                        win_q     <= winAcc_q;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        board_q    <= board_d;
                        scoreAcc_q <= scoreAcc_q + lineScore;
                        winAcc_q   <= winAcc_q | lineWin;
                        movedAcc_q <= movedAcc_q | (lineOut != lineIn);
                        lineIdx_q  <= lineIdx_q + 3'd1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grid_out  = gridOut_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign moved     = moved_q;
    assign score_add = score_q;
    assign win       = win_q;

endmodule
